// File: rtl/oet_sort_idx.sv
// Odd-even transposition sorter with arrival-index tracking.
// A frame of NUM words is loaded over a valid/ready stream. It is sorted in place
// on a key field, ascending or descending, and then streamed out with backpressure.
// Each output word carries its original arrival position.
module oet_sort_idx #(
   parameter int NUM        = 16,
   parameter int DATA_W     = 32,
   parameter int KEY_W      = 8,
   parameter int KEY_LSB    = 8,
   parameter int IDX_W      = 4,
   parameter int EARLY_EXIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              desc,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic [IDX_W:0]    phases_used
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SORT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM - 1);

   // Frame storage: words and their arrival indices, kept in registers because
   // every compare phase touches all slots at once.
   logic [DATA_W-1:0] data_q [NUM];
   logic [DATA_W-1:0] data_d [NUM];
   logic [IDX_W-1:0]  idx_q  [NUM];
   logic [IDX_W-1:0]  idx_d  [NUM];

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  wr_q, wr_d;
   logic [IDX_W-1:0]  rd_q, rd_d;
   logic [IDX_W-1:0]  phase_q, phase_d;
   logic              swap_hist_q, swap_hist_d;
   logic              desc_q, desc_d;
   logic [IDX_W:0]    phases_used_q, phases_used_d;

   // Output register stage. The word at slot rd is presented from here, so the
   // outputs hold naturally while downstream stalls.
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0]  out_index_q, out_index_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;

   logic [NUM-2:0]    swap_vec;
   logic              any_swap;
   logic              sort_done;
   logic [IDX_W-1:0]  rd_inc;

   assign rd_inc = rd_q + 1'b1;

   // Comparator between slot gi and gi+1. A pair is active only on phases
   // whose parity matches the parity of its lower slot. Even phases therefore use
   // (0,1),(2,3)... and odd phases use (1,2),(3,4)...; slots 0 and NUM-1 rest on odd phases.
   // The strict compare never swaps equal keys, so arrival order is preserved.
   for (genvar gi = 0; gi < NUM - 1; gi++) begin : g_cmp
      logic [KEY_W-1:0] key_lo;
      logic [KEY_W-1:0] key_hi;
      logic             pair_active;

      assign key_lo      = data_q[gi][KEY_LSB +: KEY_W];
      assign key_hi      = data_q[gi+1][KEY_LSB +: KEY_W];
      assign pair_active = (state_q == ST_SORT) && (phase_q[0] == 1'(gi % 2));
      assign swap_vec[gi] = pair_active &&
                            (desc_q ? (key_lo < key_hi) : (key_lo > key_hi));
   end

   assign any_swap = |swap_vec;

   // Next-state, storage update and output-stage logic for LOAD / SORT / DRAIN.
   always_comb begin
      state_d       = state_q;
      data_d        = data_q;
      idx_d         = idx_q;
      wr_d          = wr_q;
      rd_d          = rd_q;
      phase_d       = phase_q;
      swap_hist_d   = swap_hist_q;
      desc_d        = desc_q;
      phases_used_d = phases_used_q;
      out_data_d    = out_data_q;
      out_index_d   = out_index_q;
      out_valid_d   = out_valid_q;
      out_last_d    = out_last_q;
      sort_done     = 1'b0;

      case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               data_d[wr_q] = in_data;
               idx_d[wr_q]  = wr_q;
               // The sort order belongs to the frame and is taken from its first beat only.
               if (wr_q == '0) begin
                  desc_d = desc;
               end
               if (wr_q == LAST_SLOT) begin
                  wr_d    = '0;
                  phase_d = '0;
                  state_d = ST_SORT;
               end else begin
                  wr_d = wr_q + 1'b1;
               end
            end
         end

         ST_SORT: begin
            // Active pairs are disjoint, so all swaps can read from the current storage.
            for (int i = 0; i < NUM - 1; i++) begin
               if (swap_vec[i]) begin
                  data_d[i]   = data_q[i+1];
                  data_d[i+1] = data_q[i];
                  idx_d[i]    = idx_q[i+1];
                  idx_d[i+1]  = idx_q[i];
               end
            end
            swap_hist_d = any_swap;
            // An even phase and an odd phase that both have no swaps mean every
            // adjacent pair is in order, so the frame is sorted.
            sort_done = (phase_q == LAST_SLOT) ||
                        ((EARLY_EXIT != 0) && (phase_q != '0) && !any_swap && !swap_hist_q);
            if (sort_done) begin
               phases_used_d = {1'b0, phase_q} + 1'b1;
               phase_d       = '0;
               rd_d          = '0;
               state_d       = ST_DRAIN;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end

         ST_DRAIN: begin
            if (!out_valid_q) begin
               // The first DRAIN cycle fills the output stage with slot 0.
               out_valid_d = 1'b1;
               out_data_d  = data_q[rd_q];
               out_index_d = idx_q[rd_q];
               out_last_d  = (rd_q == LAST_SLOT);
            end else if (out_ready) begin
               if (rd_q == LAST_SLOT) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  rd_d        = '0;
                  state_d     = ST_LOAD;
               end else begin
                  rd_d        = rd_inc;
                  out_data_d  = data_q[rd_inc];
                  out_index_d = idx_q[rd_inc];
                  out_last_d  = (rd_inc == LAST_SLOT);
               end
            end
         end

         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // State, storage and output registers. Reset is synchronous and active-low, and it
   // discards any frame in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_LOAD;
         wr_q          <= '0;
         rd_q          <= '0;
         phase_q       <= '0;
         swap_hist_q   <= 1'b0;
         desc_q        <= 1'b0;
         phases_used_q <= '0;
         out_data_q    <= '0;
         out_index_q   <= '0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         for (int i = 0; i < NUM; i++) begin
            data_q[i] <= '0;
            idx_q[i]  <= '0;
         end
      end else begin
         state_q       <= state_d;
         wr_q          <= wr_d;
         rd_q          <= rd_d;
         phase_q       <= phase_d;
         swap_hist_q   <= swap_hist_d;
         desc_q        <= desc_d;
         phases_used_q <= phases_used_d;
         out_data_q    <= out_data_d;
         out_index_q   <= out_index_d;
         out_valid_q   <= out_valid_d;
         out_last_q    <= out_last_d;
         data_q        <= data_d;
         idx_q         <= idx_d;
      end
   end

   // Handshake and status outputs are forced low for as long as reset is held.
   assign in_ready    = rst & (state_q == ST_LOAD);
   assign busy        = rst & ((state_q == ST_SORT) || (state_q == ST_DRAIN));
   assign out_valid   = rst & out_valid_q;
   assign out_last    = rst & out_last_q;
   assign out_data    = out_data_q;
   assign out_index   = out_index_q;
   assign phases_used = phases_used_q;

endmodule

// File: tb/tb_oet_sort_idx.sv
// Self-checking bench for oet_sort_idx (NUM=8, 8-bit key at bit 8).
// Directed table vectors, fixed-length instance comparison, reset abort,
// back-to-back frames and randomized frames against a rank-based stable-sort model.
`timescale 1ns/1ps
module tb_oet_sort_idx;
   localparam int NUM     = 8;
   localparam int DATA_W  = 32;
   localparam int KEY_W   = 8;
   localparam int KEY_LSB = 8;
   localparam int IDX_W   = 3;

   typedef logic [NUM-1:0][DATA_W-1:0] frame_t;
   typedef logic [NUM-1:0][7:0]        bytes_t;

   typedef struct packed {
      bytes_t     keys;
      logic       d;
      bytes_t     exp_keys;
      bytes_t     exp_idx;
      logic [7:0] exp_phases;
      logic [7:0] exp_lat;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst, rst_ne;
   logic [DATA_W-1:0] in_data;
   logic              in_valid, desc, out_ready;
   logic              in_ready, out_valid, out_last, busy;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_index;
   logic [IDX_W:0]    phases_used;
   logic              in_ready_n, out_valid_n, out_last_n, busy_n;
   logic [DATA_W-1:0] out_data_n;
   logic [IDX_W-1:0]  out_index_n;
   logic [IDX_W:0]    phases_used_n;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int first_cyc;
   logic              seen_n;
   int                first_n;

   logic [DATA_W-1:0] got_data [NUM];
   logic [IDX_W-1:0]  got_idx  [NUM];
   logic              got_last [NUM];

   oet_sort_idx #(.NUM(NUM), .DATA_W(DATA_W), .KEY_W(KEY_W), .KEY_LSB(KEY_LSB),
                  .IDX_W(IDX_W), .EARLY_EXIT(1)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .desc(desc), .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .phases_used(phases_used)
   );

   // Fixed-length instance, held in reset except during the presorted comparison.
   oet_sort_idx #(.NUM(NUM), .DATA_W(DATA_W), .KEY_W(KEY_W), .KEY_LSB(KEY_LSB),
                  .IDX_W(IDX_W), .EARLY_EXIT(0)) dut_ne (
      .clk(clk), .rst(rst_ne), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_n),
      .desc(desc), .out_data(out_data_n), .out_index(out_index_n), .out_valid(out_valid_n),
      .out_ready(out_ready), .out_last(out_last_n), .busy(busy_n), .phases_used(phases_used_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Records when the fixed-length instance first presents a word.
   always @(negedge clk) begin
      if (!rst_ne) begin
         seen_n  <= 1'b0;
         first_n <= 0;
      end else if (out_valid_n && !seen_n) begin
         seen_n  <= 1'b1;
         first_n <= cyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bytes_t pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
      bytes_t r;
      r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
      r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
      return r;
   endfunction

   function automatic frame_t make_frame(input bytes_t keys);
      frame_t f;
      for (int i = 0; i < NUM; i++) begin
         f[i] = $urandom;
         f[i][KEY_LSB +: KEY_W] = keys[i];
      end
      return f;
   endfunction

   // Offers a frame word by word. gaps inserts random idle cycles, and desc is
   // randomized on every beat except the first. t_acc is the edge that accepts the last word.
   task automatic load_frame(input frame_t w, input logic d, input bit gaps, output int t_acc);
      int i;
      int guard;
      i = 0; guard = 0; t_acc = 0;
      while (i < NUM) begin
         @(negedge clk);
         guard++;
         if (guard > 4000) begin
            total++; bad++;
            $display("FAIL load_timeout: accepted %0d words, expected %0d", i, NUM);
            break;
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end else begin
            in_valid = 1'b1;
            in_data  = w[i];
         end
         desc = (i == 0) ? d : 1'($urandom);
         if (in_valid && in_ready) begin
            t_acc = cyc + 1;
            i++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      desc     = 1'($urandom);
   endtask

   // Drains one frame. mode 0: always ready; mode 1: ready pattern 1,0,0,1; mode 2: random.
   // The outputs must hold while stalled, and in_ready must stay low while words are presented.
   task automatic collect(input int mode);
      int n, guard, k;
      bit stalled;
      logic [DATA_W-1:0] hd;
      logic [IDX_W-1:0]  hi;
      n = 0; guard = 0; k = 0; stalled = 0; hd = '0; hi = '0;
      first_cyc = -1;
      while (n < NUM) begin
         @(negedge clk);
         guard++;
         if (guard > 4000) begin
            total++; bad++;
            $display("FAIL drain_timeout: received %0d words, expected %0d", n, NUM);
            break;
         end
         if (stalled) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_data", 64'(out_data), 64'(hd));
            chk("hold_index", 64'(out_index), 64'(hi));
         end
         if (out_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            chk("in_ready_in_drain", 64'(in_ready), 64'(0));
         end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            default: out_ready = 1'($urandom);
         endcase
         k++;
         if (out_valid && out_ready) begin
            got_data[n] = out_data;
            got_idx[n]  = out_index;
            got_last[n] = out_last;
            n++;
         end
         stalled = out_valid && !out_ready;
         hd = out_data;
         hi = out_index;
      end
      @(negedge clk);
      chk("valid_after_last", 64'(out_valid), 64'(0));
      chk("busy_after_last", 64'(busy), 64'(0));
   endtask

   // Reference: each word's output position is its stable-sort rank. That rank counts
   // the keys strictly ahead of it in the requested order, plus the equal keys that arrived earlier.
   task automatic check_model(input frame_t w, input logic d, input string tag);
      logic [DATA_W-1:0] exp_data [NUM];
      int                exp_idx  [NUM];
      int                pos;
      logic [7:0]        kj, km;
      for (int j = 0; j < NUM; j++) begin
         kj  = w[j][KEY_LSB +: KEY_W];
         pos = 0;
         for (int m = 0; m < NUM; m++) begin
            km = w[m][KEY_LSB +: KEY_W];
            if ((d ? (km > kj) : (km < kj)) || (km == kj && m < j)) pos++;
         end
         exp_data[pos] = w[j];
         exp_idx[pos]  = j;
      end
      for (int p = 0; p < NUM; p++) begin
         chk($sformatf("%s_data[%0d]", tag, p), 64'(got_data[p]), 64'(exp_data[p]));
         chk($sformatf("%s_index[%0d]", tag, p), 64'(got_idx[p]), 64'(exp_idx[p]));
         chk($sformatf("%s_last[%0d]", tag, p), 64'(got_last[p]), 64'(p == NUM - 1));
      end
   endtask

   task automatic check_vec(input frame_t w, input vec_t v, input int vi);
      for (int p = 0; p < NUM; p++) begin
         chk($sformatf("vec%0d_key[%0d]", vi, p), 64'(got_data[p][KEY_LSB +: KEY_W]), 64'(v.exp_keys[p]));
         chk($sformatf("vec%0d_index[%0d]", vi, p), 64'(got_idx[p]), 64'(v.exp_idx[p]));
         chk($sformatf("vec%0d_word[%0d]", vi, p), 64'(got_data[p]), 64'(w[v.exp_idx[p]]));
         chk($sformatf("vec%0d_last[%0d]", vi, p), 64'(got_last[p]), 64'(p == NUM - 1));
      end
   endtask

   initial begin
      vec_t   vecs [4];
      frame_t w, wa, wb;
      int     t_acc, t_b, guard, cnt;
      logic   d, da, db;
      bytes_t rk;

      vecs[0] = '{keys: pk(5,3,7,1,7,0,2,6), d: 1'b0, exp_keys: pk(0,1,2,3,5,6,7,7),
                  exp_idx: pk(5,3,6,1,0,7,2,4), exp_phases: 8'd7, exp_lat: 8'd0};
      vecs[1] = '{keys: pk(5,3,7,1,7,0,2,6), d: 1'b1, exp_keys: pk(7,7,6,5,3,2,1,0),
                  exp_idx: pk(2,4,7,0,1,6,3,5), exp_phases: 8'd7, exp_lat: 8'd0};
      vecs[2] = '{keys: pk(0,1,2,3,4,5,6,7), d: 1'b0, exp_keys: pk(0,1,2,3,4,5,6,7),
                  exp_idx: pk(0,1,2,3,4,5,6,7), exp_phases: 8'd2, exp_lat: 8'd3};
      vecs[3] = '{keys: pk(9,9,9,9,9,9,9,9), d: 1'b1, exp_keys: pk(9,9,9,9,9,9,9,9),
                  exp_idx: pk(0,1,2,3,4,5,6,7), exp_phases: 8'd2, exp_lat: 8'd3};

      rst = 1'b0; rst_ne = 1'b0; in_valid = 1'b0; in_data = '0; desc = 1'b0; out_ready = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_phases", 64'(phases_used), 64'(0));
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'(1));
      chk("post_rst_out_index", 64'(out_index), 64'(0));

      // Directed table vectors.
      for (int v = 0; v < 4; v++) begin
         w = make_frame(vecs[v].keys);
         if (vecs[v].exp_lat == 8'd3 && vecs[v].d == 1'b0) rst_ne = 1'b1;
         load_frame(w, vecs[v].d, 1'b0, t_acc);
         collect(0);
         chk($sformatf("vec%0d_phases", v), 64'(phases_used), 64'(vecs[v].exp_phases));
         if (vecs[v].exp_lat != 0)
            chk($sformatf("vec%0d_latency", v), 64'(first_cyc - t_acc), 64'(vecs[v].exp_lat));
         check_vec(w, vecs[v], v);
         if (rst_ne) begin
            guard = 0;
            while ((busy_n || !seen_n) && guard < 100) begin
               @(negedge clk);
               guard++;
            end
            chk("noexit_done", 64'(busy_n), 64'(0));
            chk("noexit_phases", 64'(phases_used_n), 64'(8));
            chk("noexit_latency", 64'(first_n - t_acc), 64'(NUM + 1));
            rst_ne = 1'b0;
         end
         $display("vector %0d desc=%0d phases_used=%0d bad_so_far=%0d", v, vecs[v].d, phases_used, bad);
      end

      // Backpressure 1,0,0,1 with input gaps.
      w = make_frame(pk(4,4,1,200,0,17,4,9));
      load_frame(w, 1'b0, 1'b1, t_acc);
      collect(1);
      check_model(w, 1'b0, "bp");
      $display("backpressure frame phases_used=%0d", phases_used);

      // Reset during SORT phase 3 aborts the frame.
      w = make_frame(pk(7,6,5,4,3,2,1,0));
      load_frame(w, 1'b0, 1'b0, t_acc);
      while (cyc < t_acc + 3) @(negedge clk);
      chk("abort_busy_before", 64'(busy), 64'(1));
      rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready_low", 64'(in_ready), 64'(0));
      chk("abort_busy_low", 64'(busy), 64'(0));
      chk("abort_valid_low", 64'(out_valid), 64'(0));
      rst = 1'b1;
      @(negedge clk);
      chk("abort_in_ready", 64'(in_ready), 64'(1));
      chk("abort_out_data", 64'(out_data), 64'(0));
      chk("abort_out_index", 64'(out_index), 64'(0));
      chk("abort_phases", 64'(phases_used), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      out_ready = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("abort_no_emit", 64'(cnt), 64'(0));
      w = make_frame(pk(3,1,2,0,3,1,2,0));
      load_frame(w, 1'b1, 1'b0, t_acc);
      collect(0);
      check_model(w, 1'b1, "after_abort");
      $display("abort sequence done phases_used=%0d", phases_used);

      // Back-to-back: frame B is offered while frame A drains.
      wa = make_frame(pk(10,2,2,8,1,1,30,5));
      wb = make_frame(pk(6,6,0,9,3,6,1,2));
      da = 1'b0; db = 1'b1;
      load_frame(wa, da, 1'b0, t_acc);
      fork
         collect(1);
         load_frame(wb, db, 1'b1, t_b);
      join
      check_model(wa, da, "b2b_a");
      collect(2);
      check_model(wb, db, "b2b_b");
      $display("back-to-back frames done");

      // Randomized frames.
      for (int f = 0; f < 25; f++) begin
         for (int i = 0; i < NUM; i++)
            rk[i] = (f % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
         w = make_frame(rk);
         d = 1'($urandom);
         load_frame(w, d, 1'($urandom), t_acc);
         collect(f % 3);
         check_model(w, d, $sformatf("rnd%0d", f));
         chk($sformatf("rnd%0d_phases_range", f),
             64'((phases_used >= 2) && (phases_used <= NUM)), 64'(1));
         chk($sformatf("rnd%0d_latency", f), 64'(first_cyc - t_acc), 64'(phases_used + 1));
         $display("random frame %0d desc=%0d phases_used=%0d", f, d, phases_used);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
